// File: rtl/chrono_pkg.sv
// chrono_pkg: state encoding, field limits and wrap-around arithmetic shared by the chrono time-setting logic.
package chrono_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam int HORA_W    = 5;
    localparam int MIN_SEG_W = 6;

    localparam logic [HORA_W-1:0]    HORA_MAX    = 5'd23;
    localparam logic [MIN_SEG_W-1:0] MIN_SEG_MAX = 6'd59;

    // One step up or down with wrap; out-of-range inputs are pulled back into 0..max_value.
    function automatic logic [MIN_SEG_W-1:0] wrap_step(
        input logic [MIN_SEG_W-1:0] value,
        input logic [MIN_SEG_W-1:0] max_value,
        input logic                 up
    );
        logic [MIN_SEG_W-1:0] result;
        if (up) begin
            result = (value >= max_value) ? '0 : value + 1'b1;
        end else begin
            result = ((value == '0) || (value > max_value)) ? max_value : value - 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, stable-level counter and one-cycle press pulse for an active-low key.
// The debounced level port exists only when CHRONO_SET_AUTOREPEAT_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
`ifdef CHRONO_SET_AUTOREPEAT_EN
    output logic level,
`endif
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= 2'b11;
            level_reg   <= 1'b1;
            level_d_reg <= 1'b1;
            press_reg   <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync_reg    <= {sync_reg[0], key};
            level_d_reg <= level_reg;
            press_reg   <= level_d_reg & ~level_reg;
            // Any sample that agrees with the accepted level restarts the count.
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync_reg[1];
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;
`ifdef CHRONO_SET_AUTOREPEAT_EN
    assign level = level_reg;
`endif

endmodule

// File: rtl/chrono_set.sv
// chrono_set: debounced key front end, field-select FSM and wrap-around editing of hh:mm:ss for the counter chain.
// Optional hold-to-repeat on up/down is enabled by defining CHRONO_SET_AUTOREPEAT_EN.
module chrono_set
    import chrono_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_BIT       = 24
) (
    input  logic                 clock_50,
    input  logic                 reset,
    input  logic                 key_mode,
    input  logic                 key_up,
    input  logic                 key_down,
    input  logic [HORA_W-1:0]    cur_horas,
    input  logic [MIN_SEG_W-1:0] cur_minutos,
    input  logic [MIN_SEG_W-1:0] cur_segundos,
    output logic [HORA_W-1:0]    set_horas,
    output logic [MIN_SEG_W-1:0] set_minutos,
    output logic [MIN_SEG_W-1:0] set_segundos,
    output logic                 load,
    output logic                 editing,
    output logic [2:0]           blink_mask,
    output logic [1:0]           state
);

    logic [2:0] key_raw;
    logic [2:0] press_vec;
    assign key_raw = {key_down, key_up, key_mode};

    genvar gi;

`ifdef CHRONO_SET_AUTOREPEAT_EN
    logic [2:0] level_vec;
`endif

    for (gi = 0; gi < 3; gi++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk   (clock_50),
            .rst_n (reset),
            .key   (key_raw[gi]),
`ifdef CHRONO_SET_AUTOREPEAT_EN
            .level (level_vec[gi]),
`endif
            .press (press_vec[gi])
        );
    end

    state_t               state_reg;
    logic [HORA_W-1:0]    set_h_reg;
    logic [MIN_SEG_W-1:0] set_m_reg;
    logic [MIN_SEG_W-1:0] set_s_reg;
    logic                 load_reg;
    logic [BLINK_BIT:0]   blink_reg;
    logic [2:0]           blink_mask_reg;

    logic mode_ev;
    logic up_ev;
    logic down_ev;
    logic step_ev;

    assign mode_ev = press_vec[0];

`ifdef CHRONO_SET_AUTOREPEAT_EN
    localparam int REPEAT_W = 25;
    localparam logic [REPEAT_W-1:0] REPEAT_FIRST_LAST = 25'd24_999_999;
    localparam logic [REPEAT_W-1:0] REPEAT_NEXT_LAST  = 25'd4_999_999;

    logic [1:0] rep_pulse;
    state_t     state_seen_reg;

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) state_seen_reg <= RUN;
        else        state_seen_reg <= state_reg;
    end

    // gi=0 repeats up, gi=1 repeats down; a release or any state change stops repeating.
    for (gi = 0; gi < 2; gi++) begin : g_repeat
        logic [REPEAT_W-1:0] cnt_reg;
        logic                active_reg;
        logic                first_reg;
        logic                pulse_reg;

        always_ff @(posedge clock_50 or negedge reset) begin
            if (!reset) begin
                cnt_reg    <= '0;
                active_reg <= 1'b0;
                first_reg  <= 1'b0;
                pulse_reg  <= 1'b0;
            end else begin
                pulse_reg <= 1'b0;
                if (press_vec[gi+1]) begin
                    cnt_reg    <= '0;
                    active_reg <= 1'b1;
                    first_reg  <= 1'b1;
                end else if (level_vec[gi+1] || (state_reg == RUN) || (state_reg != state_seen_reg)) begin
                    active_reg <= 1'b0;
                end else if (active_reg) begin
                    if (cnt_reg == (first_reg ? REPEAT_FIRST_LAST : REPEAT_NEXT_LAST)) begin
                        pulse_reg <= 1'b1;
                        cnt_reg   <= '0;
                        first_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
        end

        assign rep_pulse[gi] = pulse_reg;
    end

    assign up_ev   = press_vec[1] | rep_pulse[0];
    assign down_ev = press_vec[2] | rep_pulse[1];
`else
    assign up_ev   = press_vec[1];
    assign down_ev = press_vec[2];
`endif

    // Mode has priority; up together with down cancels out.
    assign step_ev = (up_ev ^ down_ev) && !mode_ev && (state_reg != RUN);

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            set_h_reg <= '0;
            set_m_reg <= '0;
            set_s_reg <= '0;
            load_reg  <= 1'b0;
            blink_reg <= '0;
        end else begin
            load_reg  <= 1'b0;
            blink_reg <= blink_reg + 1'b1;
            if (mode_ev) begin
                blink_reg <= '0;
                unique case (state_reg)
                    RUN: begin
                        state_reg <= SET_H;
                        set_h_reg <= cur_horas;
                        set_m_reg <= cur_minutos;
                        set_s_reg <= cur_segundos;
                    end
                    SET_H: state_reg <= SET_M;
                    SET_M: state_reg <= SET_S;
                    SET_S: begin
                        state_reg <= RUN;
                        load_reg  <= 1'b1;
                    end
                endcase
            end else if (step_ev) begin
                blink_reg <= '0;
                unique case (state_reg)
                    SET_H: set_h_reg <= HORA_W'(wrap_step(MIN_SEG_W'(set_h_reg), MIN_SEG_W'(HORA_MAX), up_ev));
                    SET_M: set_m_reg <= wrap_step(set_m_reg, MIN_SEG_MAX, up_ev);
                    SET_S: set_s_reg <= wrap_step(set_s_reg, MIN_SEG_MAX, up_ev);
                    RUN:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            blink_mask_reg <= 3'b000;
        end else begin
            unique case (state_reg)
                SET_H: blink_mask_reg <= {blink_reg[BLINK_BIT], 2'b00};
                SET_M: blink_mask_reg <= {1'b0, blink_reg[BLINK_BIT], 1'b0};
                SET_S: blink_mask_reg <= {2'b00, blink_reg[BLINK_BIT]};
                RUN:   blink_mask_reg <= 3'b000;
            endcase
        end
    end

    assign set_horas    = set_h_reg;
    assign set_minutos  = set_m_reg;
    assign set_segundos = set_s_reg;
    assign load         = load_reg;
    assign blink_mask   = blink_mask_reg;
    assign state        = state_reg;
    assign editing      = (state_reg != RUN);

endmodule
